ysyx_22041461_pipe_ctrl: RTL and testbench

Central stall/flush controller for the five-stage core: it drives `enable`/`flush` of the IF_ID, ID_EXE (EXE_reg), EXE_MEM and MEM_WB pipeline registers plus the PC enable. It resolves load-use hazards, fetch and data-memory wait states, EXE-stage redirects and traps. It also sequences the multi-cycle unit (MUL/DIV) through a start/done handshake while holding the instruction in EXE.

---
 rtl/ysyx_22041461_pipe_ctrl_if.sv | 56 +++++
 rtl/ysyx_22041461_pipe_ctrl.sv | 134 +++++++++++++
 tb/tb_ysyx_22041461_pipe_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_pipe_ctrl_if.sv
// Purpose: hazard inputs and stall/flush controls between the pipeline stages and the controller.
// Latency: none, this is wiring only.
// Backpressure: enables hold pipeline registers; active-low flushes load bubbles.
interface ysyx_22041461_pipe_ctrl_if;
   // ID stage source operands
   logic       ID_valid;
   logic       ID_use_rs1;
   logic       ID_use_rs2;
   logic [4:0] ID_rs1;
   logic [4:0] ID_rs2;
   // EXE stage occupant
   logic       EXE_valid;
   logic       EXE_is_load;
   logic       EXE_mc_op;
   logic [4:0] EXE_rd;
   logic       EXE_redirect;
   // memory handshakes, trap, multi-cycle unit
   logic       IF_req;
   logic       IF_ack;
   logic       MEM_req;
   logic       MEM_ack;
   logic       trap;
   logic       mc_done;
   logic       mc_start;
   logic       mc_kill;
   // pipeline register controls
   logic       enable_PC;
   logic       enable_IF_ID;
   logic       enable_ID_EXE;
   logic       enable_EXE_MEM;
   logic       enable_MEM_WB;
   logic       flush_IF_ID;
   logic       flush_ID_EXE;
   logic       flush_EXE_MEM;
   logic       flush_MEM_WB;

   // controller side
   modport slave (
      input  ID_valid, ID_use_rs1, ID_use_rs2, ID_rs1, ID_rs2,
      input  EXE_valid, EXE_is_load, EXE_mc_op, EXE_rd, EXE_redirect,
      input  IF_req, IF_ack, MEM_req, MEM_ack, trap, mc_done,
      output mc_start, mc_kill,
      output enable_PC, enable_IF_ID, enable_ID_EXE, enable_EXE_MEM, enable_MEM_WB,
      output flush_IF_ID, flush_ID_EXE, flush_EXE_MEM, flush_MEM_WB
   );

   // pipeline side
   modport master (
      output ID_valid, ID_use_rs1, ID_use_rs2, ID_rs1, ID_rs2,
      output EXE_valid, EXE_is_load, EXE_mc_op, EXE_rd, EXE_redirect,
      output IF_req, IF_ack, MEM_req, MEM_ack, trap, mc_done,
      input  mc_start, mc_kill,
      input  enable_PC, enable_IF_ID, enable_ID_EXE, enable_EXE_MEM, enable_MEM_WB,
      input  flush_IF_ID, flush_ID_EXE, flush_EXE_MEM, flush_MEM_WB
   );
endinterface

// File: rtl/ysyx_22041461_pipe_ctrl.sv
// Purpose: central stall/flush controller of the five-stage core, sequences MUL/DIV start/done (optional perf counters: YSYX_22041461_PERF_CNT_EN).
// Latency: all controls are combinational from the MC state and current inputs; only the MC state is registered.
// Backpressure: priority trap > mem wait > MUL/DIV > redirect > load-use > fetch wait; stalled stages hold, downstream gets a bubble.
module ysyx_22041461_pipe_ctrl (
   input  logic                            clk,
   input  logic                            rst,
   ysyx_22041461_pipe_ctrl_if.slave        bus
`ifdef YSYX_22041461_PERF_CNT_EN
   ,
   output logic [31:0]                     perf_stall_cycles,
   output logic [31:0]                     perf_flush_events
`endif
);

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_t;

   mc_state_t state;

   logic mem_stall;
   logic if_stall;
   logic load_use;
   logic mc_start_cond;
   logic mc_stall;
   logic redir;
   logic rs1_hit;
   logic rs2_hit;

   assign mem_stall     = bus.MEM_req & ~bus.MEM_ack;
   assign if_stall      = bus.IF_req & ~bus.IF_ack;
   assign rs1_hit       = bus.ID_use_rs1 & (bus.ID_rs1 == bus.EXE_rd);
   assign rs2_hit       = bus.ID_use_rs2 & (bus.ID_rs2 == bus.EXE_rd);
   assign load_use      = bus.EXE_valid & bus.EXE_is_load & bus.ID_valid &
                          (bus.EXE_rd != 5'd0) & (rs1_hit | rs2_hit);
   // The unit is started as soon as the op reaches EXE, even under a memory wait.
   assign mc_start_cond = (state == MC_IDLE) & bus.EXE_valid & bus.EXE_mc_op & ~bus.trap;
   assign mc_stall      = mc_start_cond | ((state == MC_BUSY) & ~bus.mc_done);
   assign redir         = bus.EXE_valid & bus.EXE_redirect & ~mc_stall & ~mem_stall;

   // MUL/DIV sequencing; a trap abandons the op, a stray mc_done outside MC_BUSY is ignored
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= MC_IDLE;
      end else if (bus.trap) begin
         state <= MC_IDLE;
      end else begin
         case (state)
            MC_IDLE: if (mc_start_cond) state <= MC_BUSY;
            MC_BUSY: if (bus.mc_done)   state <= mem_stall ? MC_DONE : MC_IDLE;
            MC_DONE: if (!mem_stall)    state <= MC_IDLE;
            default: state <= MC_IDLE;
         endcase
      end
   end

   // Priority-resolved enables and active-low flushes
   always_comb begin
      bus.enable_PC      = 1'b1;
      bus.enable_IF_ID   = 1'b1;
      bus.enable_ID_EXE  = 1'b1;
      bus.enable_EXE_MEM = 1'b1;
      bus.enable_MEM_WB  = 1'b1;
      bus.flush_IF_ID    = 1'b1;
      bus.flush_ID_EXE   = 1'b1;
      bus.flush_EXE_MEM  = 1'b1;
      bus.flush_MEM_WB   = 1'b1;
      bus.mc_start       = 1'b0;
      bus.mc_kill        = 1'b0;
      if (!rst) begin
         // reset clears every pipeline register
         bus.enable_PC      = 1'b0;
         bus.enable_IF_ID   = 1'b0;
         bus.enable_ID_EXE  = 1'b0;
         bus.enable_EXE_MEM = 1'b0;
         bus.enable_MEM_WB  = 1'b0;
         bus.flush_IF_ID    = 1'b0;
         bus.flush_ID_EXE   = 1'b0;
         bus.flush_EXE_MEM  = 1'b0;
         bus.flush_MEM_WB   = 1'b0;
      end else begin
         bus.mc_start = mc_start_cond;
         if (bus.trap) begin
            bus.flush_IF_ID   = 1'b0;
            bus.flush_ID_EXE  = 1'b0;
            bus.flush_EXE_MEM = 1'b0;
            bus.mc_kill       = (state != MC_IDLE);
         end else if (mem_stall) begin
            bus.enable_PC      = 1'b0;
            bus.enable_IF_ID   = 1'b0;
            bus.enable_ID_EXE  = 1'b0;
            bus.enable_EXE_MEM = 1'b0;
            bus.flush_MEM_WB   = 1'b0;
         end else if (mc_stall) begin
            // MC_DONE only persists while mem_stall is high, which the rule above
            // already covers; its release cycle lets EXE advance with the held result.
            bus.enable_PC      = 1'b0;
            bus.enable_IF_ID   = 1'b0;
            bus.enable_ID_EXE  = 1'b0;
            bus.flush_EXE_MEM  = 1'b0;
         end else if (redir) begin
            bus.flush_IF_ID    = 1'b0;
            bus.flush_ID_EXE   = 1'b0;
         end else if (load_use) begin
            bus.enable_PC      = 1'b0;
            bus.enable_IF_ID   = 1'b0;
            bus.flush_ID_EXE   = 1'b0;
         end else if (if_stall) begin
            bus.enable_PC      = 1'b0;
            bus.flush_IF_ID    = 1'b0;
         end
      end
   end

`ifdef YSYX_22041461_PERF_CNT_EN
   logic flush_event;
   // redir already excludes the mem and MUL/DIV stall cases, so only trap outranks it
   assign flush_event = bus.trap | redir;

   // Stall-cycle and flush-event counters, wrapping naturally at 2^32
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_cycles <= 32'd0;
         perf_flush_events <= 32'd0;
      end else begin
         if (!bus.enable_PC) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush_event)    perf_flush_events <= perf_flush_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_22041461_pipe_ctrl.sv
// Purpose: self-checking bench for the pipeline stall/flush controller.
// Latency: outputs compared on the falling edge, inputs changed just after the rising edge.
// Backpressure: MUL/DIV, memory-wait and trap sequences exercised by hand and by random stimulus.
module tb_ysyx_22041461_pipe_ctrl;

   typedef struct packed {
      logic       id_valid;
      logic       use1;
      logic       use2;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       exe_valid;
      logic       is_load;
      logic       mc_op;
      logic [4:0] rd;
      logic       redirect;
      logic       if_req;
      logic       if_ack;
      logic       mem_req;
      logic       mem_ack;
      logic       trap;
      logic       done;
   } stim_t;

   typedef struct {
      stim_t       in;
      logic [10:0] exp;
   } vec_t;

   // output vector: {en PC,IF_ID,ID_EXE,EXE_MEM,MEM_WB, fl IF_ID,ID_EXE,EXE_MEM,MEM_WB, start, kill}
   localparam logic [10:0] O_RUN   = 11'b11111_1111_00;
   localparam logic [10:0] O_LU    = 11'b00111_1011_00;
   localparam logic [10:0] O_REDIR = 11'b11111_0011_00;
   localparam logic [10:0] O_IFST  = 11'b01111_0111_00;
   localparam logic [10:0] O_MEMST = 11'b00001_1110_00;
   localparam logic [10:0] O_TRAP  = 11'b11111_0001_00;
   localparam logic [10:0] O_MCGO  = 11'b00011_1101_10;
   localparam logic [10:0] O_MCST  = 11'b00011_1101_00;
   localparam logic [10:0] O_KILL  = 11'b11111_0001_01;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ysyx_22041461_pipe_ctrl_if bus ();

`ifdef YSYX_22041461_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_events;
   ysyx_22041461_pipe_ctrl dut (
      .clk(clk), .rst(rst), .bus(bus),
      .perf_stall_cycles(perf_stall_cycles),
      .perf_flush_events(perf_flush_events)
   );
`else
   ysyx_22041461_pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input stim_t s);
      bus.ID_valid     = s.id_valid;
      bus.ID_use_rs1   = s.use1;
      bus.ID_use_rs2   = s.use2;
      bus.ID_rs1       = s.rs1;
      bus.ID_rs2       = s.rs2;
      bus.EXE_valid    = s.exe_valid;
      bus.EXE_is_load  = s.is_load;
      bus.EXE_mc_op    = s.mc_op;
      bus.EXE_rd       = s.rd;
      bus.EXE_redirect = s.redirect;
      bus.IF_req       = s.if_req;
      bus.IF_ack       = s.if_ack;
      bus.MEM_req      = s.mem_req;
      bus.MEM_ack      = s.mem_ack;
      bus.trap         = s.trap;
      bus.mc_done      = s.done;
   endtask

   function automatic logic [10:0] got_out();
      return {bus.enable_PC, bus.enable_IF_ID, bus.enable_ID_EXE, bus.enable_EXE_MEM,
              bus.enable_MEM_WB, bus.flush_IF_ID, bus.flush_ID_EXE, bus.flush_EXE_MEM,
              bus.flush_MEM_WB, bus.mc_start, bus.mc_kill};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // one cycle: apply stimulus, compare on the falling edge, move past the rising edge
   task automatic step(input string name, input stim_t s, input logic [10:0] exp);
      drive(s);
      @(negedge clk);
      check(name, {21'd0, got_out()}, {21'd0, exp});
      @(posedge clk);
      #1;
   endtask

   // Reference model: unit "busy" computing, or result "held" waiting for memory
   task automatic model(input stim_t s, input logic busy, input logic held,
                        output logic [10:0] o, output logic fire,
                        output logic nbusy, output logic nheld);
      logic mem, ifs, lu, idle, st, mcst, rd;
      logic [4:0] en;
      logic [3:0] fl;
      logic kill;
      mem  = s.mem_req & ~s.mem_ack;
      ifs  = s.if_req & ~s.if_ack;
      lu   = s.exe_valid && s.is_load && s.id_valid && (s.rd != 0) &&
             ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
      idle = !busy && !held;
      st   = idle && s.exe_valid && s.mc_op && !s.trap;
      mcst = st || (busy && !s.done);
      rd   = s.exe_valid && s.redirect && !mcst && !mem;
      en = 5'b11111; fl = 4'b1111; kill = 1'b0; fire = 1'b0;
      if (s.trap)      begin fl = 4'b0001; kill = !idle; fire = 1'b1; end
      else if (mem)    begin en = 5'b00001; fl = 4'b1110; end
      else if (mcst)   begin en = 5'b00011; fl = 4'b1101; end
      else if (rd)     begin fl = 4'b0011; fire = 1'b1; end
      else if (lu)     begin en = 5'b00111; fl = 4'b1011; end
      else if (ifs)    begin en = 5'b01111; fl = 4'b0111; end
      o = {en, fl, st, kill};
      nbusy = busy; nheld = held;
      if (s.trap)                begin nbusy = 1'b0; nheld = 1'b0; end
      else if (st)               nbusy = 1'b1;
      else if (busy && s.done)   begin nbusy = 1'b0; nheld = mem; end
      else if (held && !mem)     nheld = 1'b0;
   endtask

   initial begin
      vec_t  vecs[$];
      vec_t  v;
      stim_t q, s;
      int    starts, bubbles;
      logic  busy, held, nbusy, nheld, fire;
      logic  [10:0] eo;
      int unsigned m_stall, m_flush;

      q = '0;
      q.if_req = 1'b1; q.if_ack = 1'b1;

      // single-cycle vectors, all applied with the MC unit idle
      v.in = q; v.exp = O_RUN; vecs.push_back(v);
      s = q; s.exe_valid = 1; s.is_load = 1; s.rd = 5; s.id_valid = 1; s.use2 = 1; s.rs2 = 5;
      v.in = s; v.exp = O_LU; vecs.push_back(v);
      s.rd = 0; s.rs2 = 0;
      v.in = s; v.exp = O_RUN; vecs.push_back(v);
      s = q; s.exe_valid = 1; s.is_load = 1; s.rd = 7; s.id_valid = 1; s.rs1 = 7; s.use1 = 0;
      v.in = s; v.exp = O_RUN; vecs.push_back(v);
      s.use1 = 1;
      v.in = s; v.exp = O_LU; vecs.push_back(v);
      s = q; s.exe_valid = 1; s.redirect = 1;
      v.in = s; v.exp = O_REDIR; vecs.push_back(v);
      s.if_ack = 0;
      v.in = s; v.exp = O_REDIR; vecs.push_back(v);
      s = q; s.if_ack = 0;
      v.in = s; v.exp = O_IFST; vecs.push_back(v);
      s = q; s.exe_valid = 1; s.redirect = 1; s.mem_req = 1;
      v.in = s; v.exp = O_MEMST; vecs.push_back(v);
      s.trap = 1;
      v.in = s; v.exp = O_TRAP; vecs.push_back(v);
      s = q; s.if_ack = 0; s.exe_valid = 1; s.is_load = 1; s.rd = 3; s.id_valid = 1; s.use1 = 1; s.rs1 = 3;
      v.in = s; v.exp = O_LU; vecs.push_back(v);
      s = q; s.exe_valid = 1; s.mc_op = 1; s.trap = 1;
      v.in = s; v.exp = O_TRAP; vecs.push_back(v);
      s = q; s.done = 1;
      v.in = s; v.exp = O_RUN; vecs.push_back(v);

      // reset: two cycles with a MUL/DIV waiting, everything must be cleared
      rst = 1'b0;
      s = q; s.exe_valid = 1; s.mc_op = 1;
      drive(s);
      @(posedge clk); #1;
      step("reset_c0", s, 11'd0);
      step("reset_c1", s, 11'd0);
      rst = 1'b1;
      step("reset_release", q, O_RUN);

      foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);

      // MUL/DIV: done arrives four cycles after the start cycle
      starts = 0; bubbles = 0;
      s = q; s.exe_valid = 1; s.mc_op = 1;
      for (int k = 0; k <= 4; k++) begin
         s.done = (k == 4);
         drive(s);
         @(negedge clk);
         starts  += int'(bus.mc_start);
         bubbles += int'(!bus.flush_EXE_MEM);
         if (k == 4) check("mc_advance", {21'd0, got_out()}, {21'd0, O_RUN});
         @(posedge clk); #1;
      end
      check("mc_start_count", starts, 1);
      check("mc_bubbles", bubbles, 4);
      step("mc_after", q, O_RUN);

      // MUL/DIV under a memory wait, result held until MEM_ack
      s = q; s.exe_valid = 1; s.mc_op = 1; s.mem_req = 1;
      step("mcm_start", s, O_MEMST | 11'b10);
      s.done = 1;
      step("mcm_done_held", s, O_MEMST);
      s.done = 0;
      step("mcm_wait", s, O_MEMST);
      s.mem_ack = 1;
      step("mcm_release", s, O_RUN);
      // a fresh op straight after must start again, proving MC_IDLE was reached
      s = q; s.exe_valid = 1; s.mc_op = 1;
      step("mcm_next_start", s, O_MCGO);
      step("mc_busy", s, O_MCST);
      s.trap = 1;
      step("trap_kill", s, O_KILL);
      s = q; s.exe_valid = 1; s.mc_op = 1;
      step("post_trap_start", s, O_MCGO);
      s.trap = 1;
      step("trap_kill2", s, O_KILL);
      s = q; s.done = 1;
      step("stray_done", s, O_RUN);
      s = q; s.exe_valid = 1; s.redirect = 1;
      step("redirect", s, O_REDIR);
      step("redirect_after", q, O_RUN);

`ifdef YSYX_22041461_PERF_CNT_EN
      rst = 1'b0;
      step("perf_reset", q, 11'd0);
      rst = 1'b1;
      s = q; s.exe_valid = 1; s.is_load = 1; s.rd = 5; s.id_valid = 1; s.use2 = 1; s.rs2 = 5;
      step("perf_lu", s, O_LU);
      s = q; s.exe_valid = 1; s.redirect = 1;
      step("perf_redir", s, O_REDIR);
      drive(q);
      @(negedge clk);
      check("perf_stall", perf_stall_cycles, 32'd1);
      check("perf_flush", perf_flush_events, 32'd1);
      @(posedge clk); #1;
`endif

      // random phase against the reference model
      rst = 1'b0;
      drive(q);
      @(posedge clk); #1;
      busy = 1'b0; held = 1'b0; m_stall = 0; m_flush = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(31) != 0);
         s.id_valid  = $urandom_range(1);
         s.use1      = $urandom_range(1);
         s.use2      = $urandom_range(1);
         s.rs1       = 5'($urandom_range(3));
         s.rs2       = 5'($urandom_range(3));
         s.exe_valid = ($urandom_range(3) != 0);
         s.is_load   = $urandom_range(1);
         s.mc_op     = ($urandom_range(3) == 0);
         s.rd        = 5'($urandom_range(3));
         s.redirect  = ($urandom_range(3) == 0);
         s.if_req    = $urandom_range(1);
         s.if_ack    = $urandom_range(1);
         s.mem_req   = $urandom_range(1);
         s.mem_ack   = $urandom_range(1);
         s.trap      = ($urandom_range(15) == 0);
         s.done      = ($urandom_range(3) == 0);
         drive(s);
         model(s, busy, held, eo, fire, nbusy, nheld);
         if (!rst) eo = 11'd0;
         @(negedge clk);
         check($sformatf("rand%0d", n), {21'd0, got_out()}, {21'd0, eo});
`ifdef YSYX_22041461_PERF_CNT_EN
         check($sformatf("rand_stall%0d", n), perf_stall_cycles, m_stall);
         check($sformatf("rand_flush%0d", n), perf_flush_events, m_flush);
`endif
         @(posedge clk); #1;
         if (!rst) begin
            busy = 1'b0; held = 1'b0; m_stall = 0; m_flush = 0;
         end else begin
            busy = nbusy; held = nheld;
            if (!eo[10]) m_stall++;
            if (fire)    m_flush++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
